adder_stream_scoreboard: RTL and testbench

Parametrised, clocked self-checking scoreboard for pipelined N-bit adders with carry-in and carry-out. Sits on the adder's monitor side and captures every accepted input pair into an in-order expected-result queue. Compares each DUT output beat against the queue head, keeps saturating pass/fail statistics, and flags protocol faults: unexpected output, queue overflow and latency timeout. Optionally halts on the first error.

---
 rtl/adder_stream_scoreboard_if.sv | 32 +++
 rtl/adder_stream_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_adder_stream_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_stream_scoreboard_if.sv
// -----------------------------------------------------------------------------
// adder_stream_scoreboard_if
//   Monitor-side bundle of a pipelined N-bit adder. It carries the input beats
//   the adder accepted and the result beats it produced.
//
//   in_valid / in_a / in_b / in_cin    : input beat accepted by the adder
//   out_valid / out_sum / out_cout     : result beat produced by the adder
//
//   master : the side that drives the beats (adder monitor or testbench)
//   slave  : the side that observes them (the scoreboard)
// -----------------------------------------------------------------------------
interface adder_stream_scoreboard_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_valid, out_sum, out_cout
  );

  modport slave (
    input in_valid, in_a, in_b, in_cin,
    input out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_stream_scoreboard.sv
// -----------------------------------------------------------------------------
// adder_stream_scoreboard
//   In-order scoreboard for a pipelined adder with carry-in/carry-out. Every
//   accepted input pair is turned into its expected {cout, sum} and queued.
//   Each output beat is compared against the queue head. Pass/fail counts
//   saturate. Protocol faults are flagged: output with an empty queue, push
//   into a full queue, and a head that waits too long for its result.
//
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   mon             : monitored beats (slave modport)
//   exp_count       : entries currently queued
//   exp_full        : queue holds DEPTH entries
//   pass_cnt        : matched beats (saturating)
//   fail_cnt        : failed checks of any kind (saturating)
//   mismatch        : one-cycle pulse for a cycle that had any failed check
//   err             : sticky error flag
//   err_code        : first error cause (1 data, 2 unexpected, 3 overflow,
//                     4 timeout)
//   halted          : checking frozen after the first error (STOP_ON_ERR=1)
// -----------------------------------------------------------------------------
module adder_stream_scoreboard #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int MAX_LAT     = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  adder_stream_scoreboard_if.slave mon,
  output logic [$clog2(DEPTH):0]   exp_count,
  output logic                     exp_full,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              fail_cnt,
  output logic                     mismatch,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic                     halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] MAX_AGE  = TMR_W'(MAX_LAT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_DATA  = 3'd1;
  localparam logic [2:0] E_UNEXP = 3'd2;
  localparam logic [2:0] E_OVF   = 3'd3;
  localparam logic [2:0] E_TMO   = 3'd4;

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TMR_W-1:0] age;
  logic [1:0]       state;

  logic             run;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop_head;
  logic             data_ok;
  logic             data_err;
  logic             unexp;
  logic             overflow;
  logic             timeout;
  logic [1:0]       n_fail;
  logic [2:0]       first_code;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       state_next;
  logic [WIDTH:0]   push_val;
  logic [WIDTH:0]   act_val;
  logic [16:0]      fail_sum;

  assign run   = (state != ST_HALT);
  assign empty = (exp_count == '0);
  assign full  = (exp_count == FULL_CNT);

  // Full-width sum: the carry-out lands in the top bit.
  assign push_val = {1'b0, mon.in_a} + {1'b0, mon.in_b} + (WIDTH+1)'(mon.in_cin);
  assign act_val  = {mon.out_cout, mon.out_sum};

  // NOTE: every signal gets a default before any branch so no path can
  // leave it holding its old value, which would infer a latch.
  always_comb begin
    pop        = run && mon.out_valid && !empty;
    unexp      = run && mon.out_valid && empty;
    data_err   = pop && (act_val != mem[rd_ptr]);
    data_ok    = pop && !data_err;
    // A real pop in the same cycle wins over the age limit.
    timeout    = run && !empty && !pop && (age == MAX_AGE);
    // A timeout discard does not make room for a same-cycle push.
    overflow   = run && mon.in_valid && full && !pop;
    push       = run && mon.in_valid && !overflow;
    drop_head  = pop || timeout;
    n_fail     = 2'(data_err) + 2'(unexp) + 2'(overflow) + 2'(timeout);
    count_next = exp_count + CNT_W'(push) - CNT_W'(drop_head);
    fail_sum   = {1'b0, fail_cnt} + 17'(n_fail);

    first_code = E_NONE;
    if (data_err)      first_code = E_DATA;
    else if (unexp)    first_code = E_UNEXP;
    else if (overflow) first_code = E_OVF;
    else if (timeout)  first_code = E_TMO;

    if (STOP_ON_ERR && (n_fail != 2'd0)) state_next = ST_HALT;
    else if (count_next != '0)           state_next = ST_ACTIVE;
    else                                 state_next = ST_IDLE;
  end

  // NOTE: the queue storage is deliberately not reset; count and pointers
  // alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= push_val;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values
  // no matter how the statements below are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      age       <= '0;
      state     <= ST_IDLE;
      exp_count <= '0;
      exp_full  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      halted    <= 1'b0;
    end else if (run) begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (drop_head) rd_ptr <= rd_ptr + 1'b1;
      exp_count <= count_next;
      exp_full  <= (count_next == FULL_CNT);
      // Age of the current head: restarts on every pop and while empty.
      age       <= (drop_head || count_next == '0) ? '0 : age + 1'b1;
      if (data_ok && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      fail_cnt  <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
      mismatch  <= (n_fail != 2'd0);
      if (n_fail != 2'd0 && !err) begin
        err      <= 1'b1;
        err_code <= first_code;
      end
      state     <= state_next;
      halted    <= (state_next == ST_HALT);
    end else begin
      // Frozen: only the pulse output falls back.
      mismatch <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_stream_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_adder_stream_scoreboard
//   Drives two scoreboards (STOP_ON_ERR=0 and 1) from one monitor bundle.
//   Directed table vectors, hand-written multi-cycle sequences, and a random
//   run compared against a queue-based reference model of the scoreboard.
// -----------------------------------------------------------------------------
module tb_adder_stream_scoreboard;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 8;
  localparam int MAX_LAT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_stream_scoreboard_if #(.WIDTH(WIDTH)) mon_if ();

  logic [3:0]  c0_count, c1_count;
  logic        c0_full, c1_full;
  logic [15:0] c0_pass, c1_pass, c0_fail, c1_fail;
  logic        c0_mis, c1_mis, c0_err, c1_err;
  logic [2:0]  c0_code, c1_code;
  logic        c0_halted, c1_halted;

  adder_stream_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT),
                            .STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .mon(mon_if),
    .exp_count(c0_count), .exp_full(c0_full), .pass_cnt(c0_pass),
    .fail_cnt(c0_fail), .mismatch(c0_mis), .err(c0_err),
    .err_code(c0_code), .halted(c0_halted)
  );

  adder_stream_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT),
                            .STOP_ON_ERR(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .mon(mon_if),
    .exp_count(c1_count), .exp_full(c1_full), .pass_cnt(c1_pass),
    .fail_cnt(c1_fail), .mismatch(c1_mis), .err(c1_err),
    .err_code(c1_code), .halted(c1_halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_of(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return 5'(s);
  endfunction

  // ---------------- reference model (STOP_ON_ERR=0 instance) ----------------
  logic [4:0] m_q[$];
  int m_timer, m_pass, m_fail, m_code;
  bit m_err, m_mis;

  task automatic model_step(input bit r, input bit iv, input logic [3:0] a, input logic [3:0] b,
                            input logic cin, input bit ov, input logic [4:0] act);
    int sz0, nf, code;
    bit popped, tmo, ovf;
    if (r) begin
      m_q.delete();
      m_timer = 0; m_pass = 0; m_fail = 0; m_code = 0; m_err = 0; m_mis = 0;
      return;
    end
    sz0 = m_q.size(); nf = 0; code = 0; popped = 0;
    if (ov) begin
      if (sz0 == 0) begin
        nf++; code = 2;
      end else begin
        popped = 1;
        if (m_q.pop_front() == act) m_pass = (m_pass < 65535) ? m_pass + 1 : 65535;
        else begin nf++; code = 1; end
      end
    end
    tmo = !popped && sz0 != 0 && m_timer == MAX_LAT;
    if (tmo) begin
      void'(m_q.pop_front());
      nf++;
      if (code == 0) code = 4;
    end
    ovf = iv && sz0 == DEPTH && !popped;
    if (ovf) begin
      nf++;
      if (code == 0 || code > 3) code = 3;
    end else if (iv) begin
      m_q.push_back(exp_of(a, b, cin));
    end
    m_timer = (popped || tmo || m_q.size() == 0) ? 0 : m_timer + 1;
    m_fail  = (m_fail + nf > 65535) ? 65535 : m_fail + nf;
    m_mis   = (nf != 0);
    if (nf != 0 && !m_err) begin
      m_err = 1; m_code = code;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " count"},  c0_count,  m_q.size());
    check({tag, " full"},   c0_full,   m_q.size() == DEPTH);
    check({tag, " pass"},   c0_pass,   m_pass);
    check({tag, " fail"},   c0_fail,   m_fail);
    check({tag, " mis"},    c0_mis,    m_mis);
    check({tag, " err"},    c0_err,    m_err);
    check({tag, " code"},   c0_code,   m_code);
    check({tag, " halted"}, c0_halted, 0);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, " count"},  c0_count,  0);
    check({tag, " full"},   c0_full,   0);
    check({tag, " pass"},   c0_pass,   0);
    check({tag, " fail"},   c0_fail,   0);
    check({tag, " mis"},    c0_mis,    0);
    check({tag, " err"},    c0_err,    0);
    check({tag, " code"},   c0_code,   0);
    check({tag, " halted"}, c0_halted, 0);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, return at
  // the next falling edge where outputs are sampled.
  task automatic cycle(input bit r, input bit iv, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input bit ov, input logic [3:0] s, input logic co);
    rst              = r;
    mon_if.in_valid  = iv;
    mon_if.in_a      = a;
    mon_if.in_b      = b;
    mon_if.in_cin    = cin;
    mon_if.out_valid = ov;
    mon_if.out_sum   = s;
    mon_if.out_cout  = co;
    @(posedge clk);
    model_step(r, iv, a, b, cin, ov, {co, s});
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         iv;
    logic [3:0] a;
    logic [3:0] b;
    bit         cin;
    bit         ov;
    logic [3:0] s;
    bit         co;
    int         e_count;
    int         e_pass;
    int         e_fail;
    bit         e_mis;
    bit         e_err;
    int         e_code;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pa, pb;
    logic       pc;
    logic [4:0] act;
    int         piv, pov;
    bit         iv, ov;
    logic [3:0] ra, rb;
    logic       rc;

    //           iv a  b  ci ov s  co  cnt pas fal mis err code
    vecs[0]  = '{1, 7, 9, 1, 0, 0, 0,  1,  0,  0,  0,  0,  0};
    vecs[1]  = '{0, 0, 0, 0, 1, 1, 1,  0,  1,  0,  0,  0,  0};
    vecs[2]  = '{1, 7, 9, 1, 0, 0, 0,  1,  1,  0,  0,  0,  0};
    vecs[3]  = '{0, 0, 0, 0, 1, 1, 0,  0,  1,  1,  1,  1,  1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,  0,  1,  1,  0,  1,  1};
    vecs[5]  = '{0, 0, 0, 0, 1, 0, 0,  0,  1,  2,  1,  1,  1};
    vecs[6]  = '{1, 3, 4, 0, 1, 0, 0,  1,  1,  3,  1,  1,  1};
    vecs[7]  = '{0, 0, 0, 0, 1, 7, 0,  0,  2,  3,  0,  1,  1};
    vecs[8]  = '{1, 15,15,1, 0, 0, 0,  1,  2,  3,  0,  1,  1};
    vecs[9]  = '{1, 0, 0, 0, 1, 15,1,  1,  3,  3,  0,  1,  1};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 0,  0,  4,  3,  0,  1,  1};

    do_reset();
    check_zero0("reset");
    check("reset halt_dut halted", c1_halted, 0);

    for (int i = 0; i < 11; i++) begin
      cycle(0, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].ov, vecs[i].s, vecs[i].co);
      check($sformatf("vec%0d count", i), c0_count, vecs[i].e_count);
      check($sformatf("vec%0d full", i),  c0_full,  0);
      check($sformatf("vec%0d pass", i),  c0_pass,  vecs[i].e_pass);
      check($sformatf("vec%0d fail", i),  c0_fail,  vecs[i].e_fail);
      check($sformatf("vec%0d mis", i),   c0_mis,   vecs[i].e_mis);
      check($sformatf("vec%0d err", i),   c0_err,   vecs[i].e_err);
      check($sformatf("vec%0d code", i),  c0_code,  vecs[i].e_code);
    end

    // Mismatch, then 20 back-to-back passing beats: err stays sticky.
    do_reset();
    cycle(0, 1, 7, 9, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 4'h1, 0);
    check("mm pulse", c0_mis, 1);
    check("mm code", c0_code, 1);
    pa = 0; pb = 0; pc = 0;
    for (int i = 0; i <= 20; i++) begin
      act = exp_of(pa, pb, pc);
      cycle(0, i < 20, 4'(i), 4'(3 * i), 1'(i), i > 0, act[3:0], act[4]);
      if (i == 0) check("mm pulse end", c0_mis, 0);
      pa = 4'(i); pb = 4'(3 * i); pc = 1'(i);
    end
    check("mm pass", c0_pass, 20);
    check("mm fail", c0_fail, 1);
    check("mm err sticky", c0_err, 1);
    check("mm code kept", c0_code, 1);
    check("mm count", c0_count, 0);

    // Overflow: 9 pushes into an 8-deep queue, push+pop while full, drain.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, 4'(i), 1, 0, 0, 0, 0);
      if (i == 7) begin
        check("ovf full", c0_full, 1);
        check("ovf count8", c0_count, 8);
        check("ovf no err yet", c0_err, 0);
      end
    end
    check("ovf count", c0_count, 8);
    check("ovf code", c0_code, 3);
    check("ovf fail", c0_fail, 1);
    check("ovf mis", c0_mis, 1);
    act = exp_of(0, 1, 0);
    cycle(0, 1, 9, 1, 0, 1, act[3:0], act[4]);
    check("full pushpop count", c0_count, 8);
    check("full pushpop fail", c0_fail, 1);
    check("full pushpop pass", c0_pass, 1);
    for (int i = 1; i <= 8; i++) begin
      act = (i == 8) ? exp_of(9, 1, 0) : exp_of(4'(i), 1, 0);
      cycle(0, 0, 0, 0, 0, 1, act[3:0], act[4]);
    end
    check("drain pass", c0_pass, 9);
    check("drain count", c0_count, 0);
    check("drain full", c0_full, 0);
    check("drain fail", c0_fail, 1);

    // Timeout on both instances; the STOP_ON_ERR one halts and freezes.
    do_reset();
    cycle(0, 1, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) idle();
    check("tmo before count", c0_count, 1);
    check("tmo before err", c0_err, 0);
    check("tmo before halted", c1_halted, 0);
    idle();
    check("tmo count", c0_count, 0);
    check("tmo code", c0_code, 4);
    check("tmo fail", c0_fail, 1);
    check("tmo mis", c0_mis, 1);
    check("tmo c0 halted", c0_halted, 0);
    check("halt halted", c1_halted, 1);
    check("halt code", c1_code, 4);
    check("halt fail", c1_fail, 1);
    for (int k = 0; k < 5; k++) cycle(0, 1, 4'(k), 4'(k), 0, 1, 0, 0);
    check("halt frozen count", c1_count, 0);
    check("halt frozen pass", c1_pass, 0);
    check("halt frozen fail", c1_fail, 1);
    check("halt frozen mis", c1_mis, 0);
    check("halt still halted", c1_halted, 1);
    do_reset();
    check("halt rst halted", c1_halted, 0);
    check("halt rst err", c1_err, 0);
    check("halt rst fail", c1_fail, 0);

    // Reset mid-run with entries queued and err set.
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 4'(i), 2, 1, 0, 0, 0);
    check("mid count", c0_count, 5);
    check("mid err", c0_err, 1);
    do_reset();
    check_zero0("midrst");
    cycle(0, 1, 2, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 4'h5, 0);
    check("post pass", c0_pass, 1);
    check("post fail", c0_fail, 0);
    check("post err", c0_err, 0);
    check("post count", c0_count, 0);

    // Random run against the reference model, three traffic mixes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case (i / 1000)
        0:       begin piv = 50; pov = 50; end
        1:       begin piv = 80; pov = 20; end
        default: begin piv = 10; pov = 6;  end
      endcase
      iv = ($urandom_range(99) < piv);
      ov = ($urandom_range(99) < pov);
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      if (m_q.size() != 0 && $urandom_range(9) != 0) act = m_q[0];
      else act = 5'($urandom);
      cycle(0, iv, ra, rb, rc, ov, act[3:0], act[4]);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
